// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ============================================================================
//  sum_uart_pkg
//  Shared types, ASCII constants and helpers for the sum-to-UART frame
//  sequencer.
//  Revision: 1.0
// ============================================================================
package sum_uart_pkg;

  // Sequencer states; explicit 3-bit encoding
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_STROBE    = 3'd2,
    ST_WAIT_ACK  = 3'd3,
    ST_WAIT_DONE = 3'd4,
    ST_FINISH    = 3'd5
  } seq_state_t;

  // ASCII characters used in the "A+B=SS" frame
  localparam logic [7:0] PLUS   = 8'h2B;
  localparam logic [7:0] EQUALS = 8'h3D;
  localparam logic [7:0] CR     = 8'h0D;
  localparam logic [7:0] LF     = 8'h0A;
  localparam logic [7:0] ZERO   = 8'h30;

  // Frame lengths with and without the CR/LF trailer
  localparam int FRAME_LEN_SHORT = 6;
  localparam int FRAME_LEN_CRLF  = 8;
  localparam int IDX_W           = 3;

  // One hex nibble to uppercase ASCII ('0'-'9', 'A'-'F')
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    // 8'h37 is 'A' minus ten
    return (n < 4'd10) ? (ZERO + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_tx_sequencer_if.sv
`default_nettype none
// ============================================================================
//  sum_tx_sequencer_if
//  Transmit-side handshake between the frame sequencer (master) and the
//  UART transmitter (slave): byte, start strobe and busy flag.
//  Revision: 1.0
// ============================================================================
interface sum_tx_sequencer_if;

  logic [7:0] uart_tx_data;
  logic       uart_tx_start;
  logic       uart_busy;

  modport master (
    output uart_tx_data,
    output uart_tx_start,
    input  uart_busy
  );

  modport slave (
    input  uart_tx_data,
    input  uart_tx_start,
    output uart_busy
  );

endinterface
`default_nettype wire

// File: rtl/tx_frame_mux.sv
`default_nettype none
// ============================================================================
//  tx_frame_mux
//  Combinational byte selector: operand/sum snapshot plus byte index give
//  the ASCII byte of the "A+B=SS\r\n" frame.
//  Revision: 1.0
// ============================================================================
module tx_frame_mux
  import sum_uart_pkg::*;
(
  input  logic [3:0]       op_a,
  input  logic [3:0]       op_b,
  input  logic [4:0]       sum,
  input  logic [IDX_W-1:0] idx,
  output logic [7:0]       frame_byte
);

  // Select the frame character for the current index
  always_comb begin
    frame_byte = 8'h00;
    case (idx)
      3'd0: frame_byte = hex_ascii(op_a);
      3'd1: frame_byte = PLUS;
      3'd2: frame_byte = hex_ascii(op_b);
      3'd3: frame_byte = EQUALS;
      3'd4: frame_byte = ZERO + {7'b0, sum[4]};
      3'd5: frame_byte = hex_ascii(sum[3:0]);
      3'd6: frame_byte = CR;
      3'd7: frame_byte = LF;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/sum_tx_sequencer.sv
`default_nettype none
// ============================================================================
//  sum_tx_sequencer
//  Snapshots A, B and their sum on a send request and feeds the UART the
//  ASCII frame "A+B=SS" (optionally followed by CR/LF) one byte at a time
//  over a start/busy handshake, with an acknowledge timeout per byte.
//  Revision: 1.0
// ============================================================================
module sum_tx_sequencer
  import sum_uart_pkg::*;
#(
  parameter int CRLF_EN     = 1,
  parameter int ACK_TIMEOUT = 16   // legal range 2..255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      send,
  input  logic [3:0]                operand_a,
  input  logic [3:0]                operand_b,
  input  logic [4:0]                sum_in,
  sum_tx_sequencer_if.master        uart,
  output logic                      seq_busy,
  output logic                      frame_done,
  output logic                      frame_err
);

  localparam logic [IDX_W-1:0] LAST_IDX =
    (CRLF_EN != 0) ? IDX_W'(FRAME_LEN_CRLF - 1) : IDX_W'(FRAME_LEN_SHORT - 1);
  localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);

  seq_state_t       state;
  logic [3:0]       snap_a;
  logic [3:0]       snap_b;
  logic [4:0]       snap_sum;
  logic [IDX_W-1:0] idx;
  logic [7:0]       ack_cnt;
  logic [7:0]       ack_cnt_next;
  logic [7:0]       mux_byte;

  assign ack_cnt_next = ack_cnt + 8'd1;

  // Frame bytes come only from the snapshot, never from live inputs
  tx_frame_mux u_mux (
    .op_a       (snap_a),
    .op_b       (snap_b),
    .sum        (snap_sum),
    .idx        (idx),
    .frame_byte (mux_byte)
  );

  // Sequencer FSM with snapshot, index and timeout counters; all outputs registered
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      snap_a             <= 4'h0;
      snap_b             <= 4'h0;
      snap_sum           <= 5'h00;
      idx                <= '0;
      ack_cnt            <= 8'h00;
      uart.uart_tx_data  <= 8'h00;
      uart.uart_tx_start <= 1'b0;
      seq_busy           <= 1'b0;
      frame_done         <= 1'b0;
      frame_err          <= 1'b0;
    end else begin
      // Pulse outputs default low; each is raised for a single cycle below
      uart.uart_tx_start <= 1'b0;
      frame_done         <= 1'b0;
      frame_err          <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (send) begin
            snap_a   <= operand_a;
            snap_b   <= operand_b;
            snap_sum <= sum_in;
            idx      <= '0;
            seq_busy <= 1'b1;
            state    <= ST_LOAD;
          end
        end

        ST_LOAD: begin
          uart.uart_tx_data <= mux_byte;
          if (!uart.uart_busy) begin
            uart.uart_tx_start <= 1'b1;
            state              <= ST_STROBE;
          end
        end

        ST_STROBE: begin
          ack_cnt <= 8'h00;
          state   <= ST_WAIT_ACK;
        end

        ST_WAIT_ACK: begin
          if (uart.uart_busy) begin
            state <= ST_WAIT_DONE;
          end else begin
            ack_cnt <= ack_cnt_next;
            // UART never accepted the byte: drop the whole frame
            if (ack_cnt_next == ACK_LAST) begin
              frame_err <= 1'b1;
              seq_busy  <= 1'b0;
              state     <= ST_IDLE;
            end
          end
        end

        ST_WAIT_DONE: begin
          if (!uart.uart_busy) begin
            if (idx == LAST_IDX) begin
              frame_done <= 1'b1;
              state      <= ST_FINISH;
            end else begin
              idx   <= idx + 1'b1;
              state <= ST_LOAD;
            end
          end
        end

        ST_FINISH: begin
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end

        default: begin
          seq_busy <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sum_tx_sequencer.md
# sum_tx_sequencer

Frame sequencer between the operand/sum datapath and the UART transmitter. On a send request it snapshots operands A and B and their 5-bit sum, then feeds the UART one byte at a time as the ASCII frame `A+B=SS` plus optional CR/LF. It uses a start/busy handshake with the UART. It sits beside the adder inside the top-level system and is the only driver of the UART transmit inputs.

## Interface
Parameters:
- `CRLF_EN`, 1: when 1, CR (0x0D) and LF (0x0A) are appended, giving an 8-byte frame; when 0 the frame is 6 bytes.
- `ACK_TIMEOUT`, 16: cycles to wait for `uart_busy` to rise after a strobe before aborting the frame. Range 2..255.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high reset.
- `send` input 1: frame request; sampled only in IDLE.
- `operand_a` input 4: operand A, captured when `send` is accepted.
- `operand_b` input 4: operand B, captured when `send` is accepted.
- `sum_in` input 5: A+B from the adder, captured when `send` is accepted.
- `uart_busy` input 1: UART transmitter busy flag.
- `uart_tx_data` output 8: byte presented to the UART.
- `uart_tx_start` output 1: one-cycle transmit strobe.
- `seq_busy` output 1: high whenever the state is not IDLE.
- `frame_done` output 1: one-cycle pulse after the last byte completes.
- `frame_err` output 1: one-cycle pulse on ACK timeout.

## Operation
- States: IDLE, LOAD, STROBE, WAIT_ACK, WAIT_DONE, FINISH.
- IDLE: on `send`=1, register A, B and sum, set byte index to 0, then go to LOAD. A `send` in any other state is ignored; requests are not queued.
- LOAD: load `uart_tx_data` from the frame mux at the current index. Stay in LOAD while `uart_busy`=1; go to STROBE when `uart_busy`=0.
- STROBE: `uart_tx_start`=1 for exactly this cycle. Clear the timeout counter, then go to WAIT_ACK.
- WAIT_ACK:
  - `uart_busy`=1 → WAIT_DONE.
  - Otherwise increment the counter. When the counter reaches `ACK_TIMEOUT`-1, pulse `frame_err` and go to IDLE; no `frame_done` is issued.
- WAIT_DONE: wait for `uart_busy`=0. Then:
  - last index (5, or 7 when `CRLF_EN`=1) → FINISH;
  - otherwise increment the index → LOAD.
- FINISH: `frame_done`=1 for one cycle, then go to IDLE.
- Frame bytes:
  - index 0: hex(A)
  - index 1: '+' (0x2B)
  - index 2: hex(B)
  - index 3: '=' (0x3D)
  - index 4: '0' or '1' (0x30 + sum[4])
  - index 5: hex(sum[3:0])
  - index 6: 0x0D
  - index 7: 0x0A
- hex(n) maps 0–9 to 0x30–0x39 and A–F to 0x41–0x46 (uppercase).
- The registered snapshot is the only frame source. Input changes during a frame have no effect.
- `sum_in` is used as given and is not recomputed.
- Reset values: state IDLE, `uart_tx_data`=0x00, `uart_tx_start`=0, `seq_busy`=0, `frame_done`=0, `frame_err`=0, index 0, counter 0.
- Reset mid-frame abandons the frame immediately. No further strobes are issued and no done/err pulse is produced.

## Timing
- `send` high at edge k in IDLE → `seq_busy`=1 from k+1.
- With `uart_busy` low, `uart_tx_start` is high during cycle k+2.
- `uart_tx_data` is registered. It is stable from the cycle after LOAD through WAIT_DONE, so it is valid before and during the strobe.
- Minimum per-byte overhead outside UART busy time: LOAD + STROBE + 1 ACK cycle = 3 cycles.
- `uart_busy` already high during the STROBE cycle counts as the ACK on the next cycle.
- `frame_done` occurs 1 cycle after the final `uart_busy` fall is sampled. `seq_busy` drops the cycle after that.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `sum_uart_pkg` holds:
  - the state enum;
  - the ASCII constants (`PLUS`, `EQUALS`, `CR`, `LF`, `ZERO`);
  - the `hex_ascii(4-bit)` function;
  - frame length localparams.
- Sub-module `tx_frame_mux` (combinational): snapshot + index → byte.
- The FSM, index counter, timeout counter and snapshot registers live in `sum_tx_sequencer`.

## Test plan
- A=7, B=9, sum=0x10, `CRLF_EN`=1, model UART busy for 10 cycles per byte. Required bytes in order: 0x37 0x2B 0x39 0x3D 0x31 0x30 0x0D 0x0A. Required: exactly 8 strobes and one `frame_done`.
- A=F, B=F, sum=0x1E, `CRLF_EN`=0. Required bytes: 0x46 0x2B 0x46 0x3D 0x31 0x45. `frame_done` follows the 6th byte.
- Model never raises `uart_busy`, `ACK_TIMEOUT`=16. Required: `frame_err` pulses 16 cycles after the first strobe, the state returns to IDLE, and `frame_done` never pulses.
- Pulse `send` again mid-frame and change operands to 0/0. Required: the frame is unchanged and no second frame starts. A `send` after `frame_done` starts "0+0=00".
- `uart_busy` held high at request time for 20 cycles. Required: no strobe until it falls, then the strobe occurs on the 2nd cycle after the fall.
- Assert `reset` during WAIT_DONE of byte 3. Required: all outputs at reset values the next cycle and no further strobes.
